// File: rtl/addsub_sat_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with optional signed saturation,
// result flags, a sticky overflow bit and valid/ready flow control.
module addsub_sat_pipe #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             ovfl,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic             sticky_ovfl,
    input  logic             clr_sticky
);

    localparam int NG = WIDTH / GROUP;
    localparam int NL = NG / 2;
    localparam int NU = NG - NL;
    localparam int LO = NL * GROUP;
    localparam int HI = WIDTH - LO;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 8 || GROUP < 1 || (WIDTH % GROUP) != 0 || NG < 2) begin : g_bad_params
            $error("addsub_sat_pipe: WIDTH must be a multiple of 4, at least 8, and split into at least two GROUP-bit groups");
        end
    endgenerate

    // Stage 1 combinational: operand prep, group G/P, lower-half sum and carry into the upper half
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] bit_g;
    logic [WIDTH-1:0] bit_p;
    logic [NG-1:0]    grp_g;
    logic [NG-1:0]    grp_p;
    logic [NL:0]      grp_c;
    logic [LO-1:0]    lo_sum;

    always_comb begin
        logic c;
        c      = 1'b0;
        b_eff  = sub ? ~b : b;
        bit_g  = a & b_eff;
        bit_p  = a ^ b_eff;
        grp_g  = '0;
        grp_p  = '1;
        for (int unsigned k = 0; k < NG; k++) begin
            for (int unsigned i = 0; i < GROUP; i++) begin
                grp_g[k] = bit_g[k*GROUP+i] | (bit_p[k*GROUP+i] & grp_g[k]);
                grp_p[k] = grp_p[k] & bit_p[k*GROUP+i];
            end
        end
        grp_c    = '0;
        grp_c[0] = sub;
        for (int unsigned k = 0; k < NL; k++) begin
            grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
        end
        lo_sum = '0;
        for (int unsigned k = 0; k < NL; k++) begin
            c = grp_c[k];
            for (int unsigned i = 0; i < GROUP; i++) begin
                lo_sum[k*GROUP+i] = bit_p[k*GROUP+i] ^ c;
                c = bit_g[k*GROUP+i] | (bit_p[k*GROUP+i] & c);
            end
        end
    end

    // Stage 1 registers; only the upper operand halves are kept since the lower half is already summed
    logic          s1_valid;
    logic [HI-1:0] s1_ahi;
    logic [HI-1:0] s1_bhi;
    logic          s1_sat;
    logic [NU-1:0] s1_ug;
    logic [NU-1:0] s1_up;
    logic [LO-1:0] s1_lo;
    logic          s1_chi;

    logic s2_free;
    assign s2_free  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_free;

    // Stage 2 combinational: upper-half completion, overflow detection, saturation
    logic [HI-1:0]    up_g;
    logic [HI-1:0]    up_p;
    logic [NU:0]      up_c;
    logic [HI-1:0]    hi_sum;
    logic [WIDTH-1:0] raw;
    logic             raw_ovfl;
    logic [WIDTH-1:0] result;

    always_comb begin
        logic c;
        c        = 1'b0;
        up_g     = s1_ahi & s1_bhi;
        up_p     = s1_ahi ^ s1_bhi;
        up_c     = '0;
        up_c[0]  = s1_chi;
        for (int unsigned k = 0; k < NU; k++) begin
            up_c[k+1] = s1_ug[k] | (s1_up[k] & up_c[k]);
        end
        hi_sum = '0;
        for (int unsigned k = 0; k < NU; k++) begin
            c = up_c[k];
            for (int unsigned i = 0; i < GROUP; i++) begin
                hi_sum[k*GROUP+i] = up_p[k*GROUP+i] ^ c;
                c = up_g[k*GROUP+i] | (up_p[k*GROUP+i] & c);
            end
        end
        raw      = {hi_sum, s1_lo};
        raw_ovfl = (s1_ahi[HI-1] == s1_bhi[HI-1]) && (raw[WIDTH-1] != s1_ahi[HI-1]);
        result   = raw;
        if (s1_sat && raw_ovfl) begin
            result = s1_ahi[HI-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_ahi      <= '0;
            s1_bhi      <= '0;
            s1_sat      <= 1'b0;
            s1_ug       <= '0;
            s1_up       <= '0;
            s1_lo       <= '0;
            s1_chi      <= 1'b0;
            out_valid   <= 1'b0;
            sum         <= '0;
            ovfl        <= 1'b0;
            cout        <= 1'b0;
            zero        <= 1'b0;
            neg         <= 1'b0;
            sticky_ovfl <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_ahi <= a[WIDTH-1:LO];
                    s1_bhi <= b_eff[WIDTH-1:LO];
                    s1_sat <= sat_en;
                    s1_ug  <= grp_g[NG-1:NL];
                    s1_up  <= grp_p[NG-1:NL];
                    s1_lo  <= lo_sum;
                    s1_chi <= grp_c[NL];
                end
            end
            if (s2_free) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    sum  <= result;
                    ovfl <= raw_ovfl;
                    cout <= up_c[NU];
                    zero <= (result == '0);
                    neg  <= result[WIDTH-1];
                end
            end
            // A setting transfer takes priority over a simultaneous clear
            if (out_valid && out_ready && ovfl) begin
                sticky_ovfl <= 1'b1;
            end else if (clr_sticky) begin
                sticky_ovfl <= 1'b0;
            end
        end
    end

endmodule
